fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 147 ++++++++++++++
 tb/tb_fetch_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one-deep skid buffer (HOLD) behind a registered output slot,
// with branch redirect/drain. Optional fetch counter under macro FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        isBranchTaken,
  input  logic [31:0] branchPC,
  input  logic        stall,
  output logic [31:0] Instruction,
  output logic [31:0] pc_out,
  output logic        inst_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] fetch_count,
`endif
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2, DRAIN = 2'd3} state_e;

  // Handshake: imem_req is held with imem_addr stable until the cycle imem_ack=1;
  // that cycle completes the transfer and imem_rdata is sampled on the same edge.
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic        new_word;
  logic        slot_free;

  assign slot_free   = !valid_q || !stall;
  assign imem_addr   = req_addr_q;
  assign Instruction = inst_q;
  assign pc_out      = pc_out_q;
  assign inst_valid  = valid_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    hold_inst_d = hold_inst_q;
    hold_pc_d   = hold_pc_q;
    inst_d      = inst_q;
    pc_out_d    = pc_out_q;
    valid_d     = valid_q;
    new_word    = 1'b0;
    imem_req    = (state_q == FETCH) || (state_q == DRAIN);
    case (state_q)
      IDLE: begin
        state_d    = FETCH;
        req_addr_d = pc_q;
      end
      FETCH: begin
        if (isBranchTaken) begin
          // Redirect wins over ack and stall; an unacked request must drain first.
          valid_d     = 1'b0;
          pc_d        = branchPC;
          hold_inst_d = '0;
          hold_pc_d   = '0;
          if (imem_ack) req_addr_d = branchPC;
          else          state_d    = DRAIN;
        end else if (imem_ack) begin
          pc_d       = req_addr_q + 32'd4;
          req_addr_d = req_addr_q + 32'd4;
          if (slot_free) begin
            inst_d   = imem_rdata;
            pc_out_d = req_addr_q;
            valid_d  = 1'b1;
            new_word = 1'b1;
          end else begin
            hold_inst_d = imem_rdata;
            hold_pc_d   = req_addr_q;
            state_d     = HOLD;
          end
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (isBranchTaken) begin
          valid_d     = 1'b0;
          pc_d        = branchPC;
          req_addr_d  = branchPC;
          hold_inst_d = '0;
          hold_pc_d   = '0;
          state_d     = FETCH;
        end else if (!stall) begin
          inst_d   = hold_inst_q;
          pc_out_d = hold_pc_q;
          valid_d  = 1'b1;
          new_word = 1'b1;
          state_d  = FETCH;
        end
      end
      DRAIN: begin
        valid_d = 1'b0;
        if (isBranchTaken) pc_d = branchPC;
        if (imem_ack) begin
          req_addr_d = isBranchTaken ? branchPC : pc_q;
          state_d    = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      hold_inst_q <= '0;
      hold_pc_q   <= '0;
      inst_q      <= '0;
      pc_out_q    <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      hold_inst_q <= hold_inst_d;
      hold_pc_q   <= hold_pc_d;
      inst_q      <= inst_d;
      pc_out_q    <= pc_out_d;
      valid_q     <= valid_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] count_q;
  assign fetch_count = count_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        count_q <= '0;
    else if (new_word) count_q <= count_q + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized ack/stall/redirect traffic
// compared every cycle against a transaction-level model.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        isBranchTaken;
  logic [31:0] branchPC;
  logic        stall;
  logic [31:0] Instruction;
  logic [31:0] pc_out;
  logic        inst_valid;
  logic [1:0]  dbg_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .isBranchTaken(isBranchTaken),
    .branchPC(branchPC), .stall(stall), .Instruction(Instruction), .pc_out(pc_out),
    .inst_valid(inst_valid),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count(fetch_count),
`endif
    .dbg_state_o(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Model: the stream of words is tracked as an output slot plus a queue of words
  // captured while the slot was occupied; a squashed in-flight request is a flag.
  logic        m_started, m_squashed, m_valid;
  logic [31:0] m_pc, m_addr, m_out_pc, m_out_inst, m_count;
  logic [63:0] exp_q[$];

  function automatic void model_reset();
    m_started = 0; m_squashed = 0; m_valid = 0;
    m_pc = RST_PC; m_addr = RST_PC; m_out_pc = 0; m_out_inst = 0; m_count = 0;
    exp_q.delete();
  endfunction

  function automatic void model_update(input logic a, input logic s, input logic b,
                                       input logic [31:0] bp);
    logic [63:0] w;
    if (!m_started) begin
      m_started = 1;
    end else if (exp_q.size() != 0) begin
      if (b) begin
        exp_q.delete(); m_valid = 0; m_pc = bp; m_addr = bp;
      end else if (!s) begin
        w = exp_q.pop_front();
        m_out_pc = w[63:32]; m_out_inst = w[31:0]; m_valid = 1; m_count++;
      end
    end else if (m_squashed) begin
      if (b) m_pc = bp;
      if (a) begin m_addr = m_pc; m_squashed = 0; end
    end else if (b) begin
      m_valid = 0; m_pc = bp;
      if (a) m_addr = bp; else m_squashed = 1;
    end else if (a) begin
      w = {m_addr, mem_word(m_addr)};
      m_pc = m_addr + 4; m_addr = m_addr + 4;
      if (!m_valid || !s) begin
        m_out_pc = w[63:32]; m_out_inst = w[31:0]; m_valid = 1; m_count++;
      end else exp_q.push_back(w);
    end else if (!s) begin
      m_valid = 0;
    end
  endfunction

  task automatic compare_all();
    logic exp_req;
    exp_req = m_started && (exp_q.size() == 0);
    check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    if (exp_req) check("imem_addr", imem_addr, m_addr);
    check("inst_valid", {31'd0, inst_valid}, {31'd0, m_valid});
    check("pc_out", pc_out, m_out_pc);
    check("Instruction", Instruction, m_out_inst);
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count", fetch_count, m_count);
`endif
  endtask

  task automatic step(input logic a, input logic s, input logic b, input logic [31:0] bp);
    @(negedge clk);
    compare_all();
    imem_ack = a; stall = s; isBranchTaken = b; branchPC = bp;
    imem_rdata = mem_word(imem_addr);
    @(posedge clk);
    model_update(a, s, b, bp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", Instruction, 32'd0);
    check("rst_pc_out", pc_out, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    model_reset();
    imem_ack = 0; stall = 0; isBranchTaken = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 0; imem_rdata = 0; isBranchTaken = 0; branchPC = 0; stall = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    step(1, 0, 0, 0);  // IDLE: ack ignored
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0);
      #1;
      check("seq_pc_out", pc_out, 32'(4 * k));
      check("seq_valid", {31'd0, inst_valid}, 32'd1);
      check("seq_addr", imem_addr, 32'(4 * k + 4));
    end
    step(1, 1, 0, 0);  // word 0xC captured while stalled
    #1;
    check("hold_req", {31'd0, imem_req}, 32'd0);
    check("hold_pc_out", pc_out, 32'h8);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    #1 check("hold_keep", pc_out, 32'h8);
    step(0, 0, 0, 0);
    #1;
    check("hold_release_pc", pc_out, 32'hC);
    check("hold_release_inst", Instruction, mem_word(32'hC));
    step(0, 0, 1, 32'h100);  // redirect while 0x10 pending
    #1;
    check("drain_valid", {31'd0, inst_valid}, 32'd0);
    check("drain_addr", imem_addr, 32'h10);
    step(1, 0, 0, 0);
    #1;
    check("drain_discard", {31'd0, inst_valid}, 32'd0);
    check("drain_next_addr", imem_addr, 32'h100);
    step(1, 0, 0, 0);
    #1 check("redir_pc_out", pc_out, 32'h100);
    step(1, 1, 1, 32'h40);  // redirect + ack + stall
    #1;
    check("redir_ack_valid", {31'd0, inst_valid}, 32'd0);
    check("redir_ack_addr", imem_addr, 32'h40);
    step(1, 0, 1, 32'hFFFF_FFFC);
    step(1, 0, 0, 0);
    #1;
    check("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
    check("wrap_addr", imem_addr, 32'h0);
    step(1, 1, 0, 0);  // into HOLD, then reset
    do_reset();
    step(0, 0, 0, 0);
    #1 check("post_rst_addr", imem_addr, RST_PC);

    for (int n = 0; n < 4000; n++) begin
      logic [31:0] bp;
      case ($urandom_range(0, 3))
        0:       bp = 32'hFFFF_FFFC;
        1:       bp = {24'd0, $urandom_range(0, 63), 2'b00};
        default: bp = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
      endcase
      if ($urandom_range(0, 599) == 0) do_reset();
      else step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 35,
                $urandom_range(0, 99) < 7, bp);
    end
    @(negedge clk);
    compare_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
